ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//  Instruction-fetch stage: owns the architectural PC register and fetches one instruction per PC from imem.
//  Fetches over a valid/ready request channel and a valid-only response channel.
//  Presents the fetched word to decode/execute with a valid/ready handshake.
//  Commits the next PC computed by exu_pc (pc_in/pc_w_en) only when the held instruction is consumed.
//  Halts on an invalid instruction (pc_w_en=0 at commit), a misaligned target, or an imem timeout.
// PARAMETERS
//  RESET_PC    `ISA_WIDTH'h8000_0000  PC value loaded on reset
//  TIMEOUT_W   8                      width of the response-wait counter; limit = 2**TIMEOUT_W-1 cycles
// PORTS
//  clk             in   1           clock
//  rst             in   1           reset, asynchronous, active-high
//  pc_out          out  ISA_WIDTH   current PC (feeds exu_pc, imem address)
//  pc_in           in   ISA_WIDTH   next PC from exu_pc
//  pc_w_en         in   1           next-PC valid from exu_pc
//  imem_req_valid  out  1           fetch request
//  imem_req_ready  in   1           imem accepts request
//  imem_req_addr   out  ISA_WIDTH   fetch address (= pc_out)
//  imem_rsp_valid  in   1           response data valid
//  imem_rsp_data   in   32          fetched instruction word
//  inst            out  32          held instruction
//  inst_valid      out  1           inst is valid for consumer
//  inst_ready      in   1           consumer retires inst this cycle
//  halted          out  1           stage stopped; sticky until reset
//  err_misalign    out  1           halt cause: committed pc_in[1:0]!=0
//  err_timeout     out  1           halt cause: imem response timeout
// BEHAVIOUR
//  Reset (async, rst=1):
//   pc_out=RESET_PC, state=S_REQ, inst=0, wait counter=0.
//   All other outputs 0; halted/err_* cleared.
//   Reset mid-fetch discards any outstanding request; a late imem_rsp_valid after reset is ignored while in S_REQ.
//  States S_REQ, S_WAIT, S_VALID, S_HALT:
//   S_REQ: imem_req_valid=1.
//    -> S_WAIT when imem_req_ready=1.
//    imem_rsp_valid is ignored; a response is never accepted in the request cycle.
//   S_WAIT: counter increments each cycle.
//    -> imem_rsp_valid=1: capture inst=imem_rsp_data, counter=0, -> S_VALID.
//    -> counter reaches 2**TIMEOUT_W-1 with no response: err_timeout=1, -> S_HALT.
//    Response wins if it arrives in the same cycle as the limit.
//   S_VALID: inst_valid=1; inst is stable until the handshake.
//    Handshake = inst_valid & inst_ready.
//    Handshake with pc_w_en=1 and pc_in[1:0]==0: pc_out<=pc_in, -> S_REQ.
//    Handshake with pc_w_en=1 and pc_in[1:0]!=0: pc_out<=pc_in, err_misalign=1, -> S_HALT.
//    Handshake with pc_w_en=0: pc_out unchanged, -> S_HALT (both err_* stay 0).
//    No handshake: pc_in/pc_w_en are ignored.
//   S_HALT: halted=1, no requests, inst_valid=0; exited only by reset.
//  Timing:
//   Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, VALID).
//   inst_valid rises 1 cycle after the response is captured.
//  Outputs are registered or decoded from state only; no combinational path from imem_* or inst_ready to outputs.
//  pc_out changes only on a commit or on reset.
// STRUCTURE
//  config.vh: add FETCH_STATE_WIDTH (2) and FETCH_S_REQ/S_WAIT/S_VALID/S_HALT encodings.
//  config.vh: add RESET_PC default.
//  Sub-module ifu_pc_reg: ISA_WIDTH register with async reset to RESET_PC and write enable.
//   Also used by the difftest probe.
//  FSM, wait counter and inst holding register stay in ifu_fetch.
// TESTING
//  1. Reset release, imem_req_ready=1, rsp one cycle later with 0x00000013:
//     -> req_addr=0x80000000; inst_valid at cycle 3 with inst=0x00000013.
//  2. inst_ready=0 for 5 cycles, then 1 with pc_w_en=1, pc_in=0x80000004:
//     -> inst held stable; pc_out=0x80000004 the next cycle; new request issued.
//  3. Commit with pc_in=0x80000102:
//     -> halted=1, err_misalign=1, pc_out=0x80000102, no further requests.
//  4. No response for 255 cycles with TIMEOUT_W=8:
//     -> err_timeout=1, halted=1.
//     Variant: response at cycle 255 -> captured, no error.
//  5. Commit with pc_w_en=0 (ebreak/illegal):
//     -> halted=1, err_*=0, pc_out unchanged.
//  6. Assert rst in S_WAIT, then give a stale rsp after release:
//     -> pc_out=0x80000000, stale rsp ignored, fresh request issued.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: ISA width, reset PC,
// fetch FSM state encoding and a small alignment helper.
package ifu_fetch_pkg;

  localparam int ISA_WIDTH         = 32;
  localparam int FETCH_STATE_WIDTH = 2;

  localparam logic [ISA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_S_REQ   = 2'd0,
    FETCH_S_WAIT  = 2'd1,
    FETCH_S_VALID = 2'd2,
    FETCH_S_HALT  = 2'd3
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic pc_aligned(input logic [ISA_WIDTH-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register: loads RESET_PC on reset, takes a new value
// only when written. Shared with the difftest probe.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [ISA_WIDTH-1:0] d,
  output logic [ISA_WIDTH-1:0] q
);

  // PC holds its value except on an explicit write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (w_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: requests one word per PC from imem, holds it for
// the consumer, and commits the next PC from exu_pc when the word retires.
// Halts (sticky until reset) on a non-committing retire, a misaligned target
// or an imem response timeout.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                   TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ISA_WIDTH-1:0] pc_out,
  input  logic [ISA_WIDTH-1:0] pc_in,
  input  logic                 pc_w_en,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ISA_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic                 halted,
  output logic                 err_misalign,
  output logic                 err_timeout
);

  // The counter value seen in the last permitted wait cycle; the response
  // is still accepted in that cycle, otherwise the fetch times out.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  fetch_state_e         state;
  fetch_state_e         state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;

  logic in_wait;
  logic rsp_take;
  logic timeout_hit;
  logic handshake;
  logic commit;

  assign in_wait     = (state == FETCH_S_WAIT);
  assign rsp_take    = in_wait & imem_rsp_valid;
  assign timeout_hit = in_wait & ~imem_rsp_valid & (wait_cnt == WAIT_LAST);
  assign handshake   = (state == FETCH_S_VALID) & inst_ready;
  assign commit      = handshake & pc_w_en;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .w_en (commit),
    .d    (pc_in),
    .q    (pc_out)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a response in the limit cycle takes priority.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH_S_REQ: begin
        if (imem_req_ready) state_nxt = FETCH_S_WAIT;
      end
      FETCH_S_WAIT: begin
        if (imem_rsp_valid)              state_nxt = FETCH_S_VALID;
        else if (wait_cnt == WAIT_LAST)  state_nxt = FETCH_S_HALT;
      end
      FETCH_S_VALID: begin
        if (inst_ready) begin
          if (pc_w_en && pc_aligned(pc_in)) state_nxt = FETCH_S_REQ;
          else                              state_nxt = FETCH_S_HALT;
        end
      end
      FETCH_S_HALT: state_nxt = FETCH_S_HALT;
      default:      state_nxt = FETCH_S_HALT;
    endcase
  end

  // Response-wait counter: runs only while waiting, cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (in_wait && !imem_rsp_valid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Instruction holding register: loads only on an accepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst <= '0;
    end else if (rsp_take) begin
      inst <= imem_rsp_data;
    end
  end

  // Sticky halt causes, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (commit && !pc_aligned(pc_in)) err_misalign <= 1'b1;
      if (timeout_hit)                  err_timeout  <= 1'b1;
    end
  end

  assign imem_req_valid = (state == FETCH_S_REQ);
  assign imem_req_addr  = pc_out;
  assign inst_valid     = (state == FETCH_S_VALID);
  assign halted         = (state == FETCH_S_HALT);

endmodule
